// File: rtl/note_pkg.sv
// Shared types and constants for the note spawner and its LFSR.
package note_pkg;

   localparam int                LFSR_W    = 10;
   // Feedback taps: bit 9 and bit 6 give a maximal-length (1023) sequence.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 10'h240;

   typedef logic [1:0] lane_t;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } spawn_state_e;

   // One Fibonacci step: shift left, feed the XOR of the tapped bits into bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
      return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/note_spawner_lfsr10.sv
// 10-bit Fibonacci LFSR that advances only when step is high.
module lfsr10
   import note_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 10'h001
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              step,
   output logic [LFSR_W-1:0] q
);

   // An all-zero state would lock the register up, so a zero seed becomes 1.
   localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

   logic [LFSR_W-1:0] q_q;
   logic [LFSR_W-1:0] q_d;

   // Next-state: advance on step, otherwise hold.
   always_comb begin
      q_d = step ? lfsr_next(q_q) : q_q;
   end

   // State register with asynchronous reset to the guarded seed.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (reset) q_q <= SEED_EFF;
      else       q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/note_spawner.sv
// Random note generator: beat divider, LFSR threshold compare, and a
// valid/ready offer FSM with a saturating count of notes lost to backpressure.
module note_spawner
   import note_pkg::*;
#(
   parameter logic [LFSR_W-1:0] LFSR_SEED = 10'h001,
   parameter int                BEAT_DIV  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [LFSR_W-1:0] difficulty,
   input  logic              note_ready,
   output logic              note_valid,
   output lane_t             note_lane,
   output logic              beat,
   output logic [7:0]        drop_count
);

   localparam int                CNT_W    = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BEAT_DIV - 1);

   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   spawn_state_e      state_q, state_d;
   lane_t             lane_q, lane_d;
   logic [7:0]        drop_q, drop_d;
   logic [LFSR_W-1:0] lfsr;
   logic              beat_w;
   logic              spawn;
   logic              transfer;

   // Beat strobe is a decode of the registered counter, gated by enable.
   assign beat_w   = enable && (beat_cnt_q == CNT_LAST);
   // Decision uses the pre-step LFSR value, which is what lfsr holds on the beat cycle.
   assign spawn    = beat_w && (difficulty > lfsr);
   assign transfer = (state_q == OFFER) && note_ready;

   lfsr10 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .step  (beat_w),
      .q     (lfsr)
   );

   // Beat counter: wraps at BEAT_DIV-1, holds while disabled.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (enable) beat_cnt_d = beat_w ? '0 : beat_cnt_q + 1'b1;
   end

   // Offer FSM next-state, latched lane and drop counter.
   always_comb begin
      // NOTE: defaults first so every path assigns every _d signal and no latch is inferred.
      state_d = state_q;
      lane_d  = lane_q;
      drop_d  = drop_q;
      case (state_q)
         IDLE: begin
            if (spawn) begin
               state_d = OFFER;
               lane_d  = lfsr[1:0];
            end
         end
         OFFER: begin
            if (transfer) begin
               if (spawn) lane_d  = lfsr[1:0];
               else       state_d = IDLE;
            end else if (spawn && (drop_q != 8'hFF)) begin
               drop_d = drop_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset discards any pending note immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beat_cnt_q <= '0;
         state_q    <= IDLE;
         lane_q     <= '0;
         drop_q     <= '0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         state_q    <= state_d;
         lane_q     <= lane_d;
         drop_q     <= drop_d;
      end
   end

   assign note_valid = (state_q == OFFER);
   assign note_lane  = lane_q;
   assign beat       = beat_w;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_note_spawner.sv
// Directed bench for note_spawner with BEAT_DIV=4, seed 001.
// Beat-cycle LFSR values from reset: 001,002,004,008,010,020,040,081.
module tb_note_spawner;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [9:0] difficulty;
   logic       note_ready;
   logic       note_valid;
   logic [1:0] note_lane;
   logic       beat;
   logic [7:0] drop_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   note_spawner #(
      .LFSR_SEED (10'h001),
      .BEAT_DIV  (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .difficulty (difficulty),
      .note_ready (note_ready),
      .note_valid (note_valid),
      .note_lane  (note_lane),
      .beat       (beat),
      .drop_count (drop_count)
   );

   typedef struct {
      bit         rst;
      logic [9:0] diff;
      bit         exp_spawn;
      logic [1:0] exp_lane;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs[NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Hold reset over two edges, release on a falling edge with enable high.
   task automatic do_reset();
      reset      = 1'b1;
      enable     = 1'b1;
      note_ready = 1'b0;
      difficulty = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Advance falling edges until beat is seen (bounded); returns inside the beat cycle.
   task automatic wait_beat();
      int n = 0;
      while (beat !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      check("beat_seen", beat, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;

      // Three eight-beat groups from reset: always spawn, threshold 3, strict-compare edges.
      vecs[0]  = '{1, 10'h3FF, 1, 2'd1};
      vecs[1]  = '{0, 10'h3FF, 1, 2'd2};
      vecs[2]  = '{0, 10'h3FF, 1, 2'd0};
      vecs[3]  = '{0, 10'h3FF, 1, 2'd0};
      vecs[4]  = '{0, 10'h3FF, 1, 2'd0};
      vecs[5]  = '{0, 10'h3FF, 1, 2'd0};
      vecs[6]  = '{0, 10'h3FF, 1, 2'd0};
      vecs[7]  = '{0, 10'h3FF, 1, 2'd1};
      vecs[8]  = '{1, 10'h003, 1, 2'd1};
      vecs[9]  = '{0, 10'h003, 1, 2'd2};
      vecs[10] = '{0, 10'h003, 0, 2'd0};
      vecs[11] = '{0, 10'h003, 0, 2'd0};
      vecs[12] = '{0, 10'h003, 0, 2'd0};
      vecs[13] = '{0, 10'h003, 0, 2'd0};
      vecs[14] = '{0, 10'h003, 0, 2'd0};
      vecs[15] = '{0, 10'h003, 0, 2'd0};
      vecs[16] = '{1, 10'h001, 0, 2'd0};
      vecs[17] = '{0, 10'h003, 1, 2'd2};
      vecs[18] = '{0, 10'h004, 0, 2'd0};
      vecs[19] = '{0, 10'h009, 1, 2'd0};
      vecs[20] = '{0, 10'h010, 0, 2'd0};
      vecs[21] = '{0, 10'h3FF, 1, 2'd0};
      vecs[22] = '{0, 10'h041, 1, 2'd0};
      vecs[23] = '{0, 10'h080, 0, 2'd0};

      do_reset();
      check("reset_valid", note_valid, 1'b0);
      check("reset_drop", drop_count, 8'd0);

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].rst) do_reset();
         difficulty = vecs[i].diff;
         note_ready = 1'b1;
         wait_beat();
         @(negedge clk);
         check($sformatf("v%0d_valid", i), note_valid, vecs[i].exp_spawn);
         if (vecs[i].exp_spawn) begin
            check($sformatf("v%0d_lane", i), note_lane, vecs[i].exp_lane);
            @(negedge clk);
            check($sformatf("v%0d_one_cycle", i), note_valid, 1'b0);
         end
      end

      // difficulty=0 never spawns over 20 beats.
      do_reset();
      note_ready = 1'b1;
      for (int b = 0; b < 20; b++) begin
         wait_beat();
         @(negedge clk);
         check($sformatf("d0_beat%0d_valid", b), note_valid, 1'b0);
      end
      check("d0_drop", drop_count, 8'd0);

      // Backpressure over three beats: lane 1 held, two drops, then accepted.
      do_reset();
      difficulty = 10'h3FF;
      for (int b = 0; b < 3; b++) begin
         wait_beat();
         @(negedge clk);
      end
      check("bp_valid", note_valid, 1'b1);
      check("bp_lane", note_lane, 2'd1);
      check("bp_drop", drop_count, 8'd2);
      note_ready = 1'b1;
      @(negedge clk);
      check("bp_accept_idle", note_valid, 1'b0);
      check("bp_drop_kept", drop_count, 8'd2);
      note_ready = 1'b0;
      wait_beat();
      @(negedge clk);
      check("bp_next_valid", note_valid, 1'b1);
      check("bp_next_lane", note_lane, 2'd0);

      // Asynchronous reset in the middle of an offer clears outputs without a clock edge.
      #2;
      reset = 1'b1;
      #1;
      check("arst_valid", note_valid, 1'b0);
      check("arst_lane", note_lane, 2'd0);
      check("arst_drop", drop_count, 8'd0);
      check("arst_beat", beat, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rel_beat_c1", beat, 1'b0);
      @(negedge clk);
      check("rel_beat_c2", beat, 1'b0);
      @(negedge clk);
      check("rel_beat_c3", beat, 1'b1);
      @(negedge clk);
      check("rel_seed_valid", note_valid, 1'b1);
      check("rel_seed_lane", note_lane, 2'd1);

      // enable=0 mid-offer: no beats, pending note still completes, LFSR holds.
      do_reset();
      difficulty = 10'h3FF;
      wait_beat();
      @(negedge clk);
      check("en_offer_lane", note_lane, 2'd1);
      enable = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (beat !== 1'b0 || note_valid !== 1'b1) seen = 1'b1;
      end
      check("en_hold_offer", seen, 1'b0);
      note_ready = 1'b1;
      @(negedge clk);
      check("en_drain", note_valid, 1'b0);
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (note_valid !== 1'b0 || beat !== 1'b0) seen = 1'b1;
      end
      check("en_no_spawn", seen, 1'b0);
      enable = 1'b1;
      wait_beat();
      @(negedge clk);
      check("en_resume_valid", note_valid, 1'b1);
      check("en_resume_lane", note_lane, 2'd2);

      // Back-to-back: ready only on the beat-2 cycle while lane 1 is offered.
      do_reset();
      difficulty = 10'h3FF;
      wait_beat();
      @(negedge clk);
      check("b2b_first_lane", note_lane, 2'd1);
      wait_beat();
      check("b2b_pre_lane", note_lane, 2'd1);
      note_ready = 1'b1;
      @(negedge clk);
      note_ready = 1'b0;
      check("b2b_valid", note_valid, 1'b1);
      check("b2b_lane", note_lane, 2'd2);
      check("b2b_drop", drop_count, 8'd0);

      // Keep refusing notes until the drop counter must saturate.
      for (int b = 0; b < 265; b++) begin
         wait_beat();
         @(negedge clk);
      end
      check("sat_drop", drop_count, 8'd255);
      check("sat_lane_held", note_lane, 2'd2);
      for (int b = 0; b < 3; b++) begin
         wait_beat();
         @(negedge clk);
      end
      check("sat_drop_hold", drop_count, 8'd255);
      check("sat_valid", note_valid, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
